// File: rtl/noc_port_arbiter_if.sv
// Handshake bundle between N_REQ packetizer requesters, the arbiter and one fabric-port input node.
// No storage of its own: the arbiter's output register sits behind the slave modport.
// Backpressure: the fabric's ready enters as i_ready. The arbiter answers each requester with o_ready.
interface noc_port_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int WIDTH_PKT = 512
);
  localparam int SRC_WIDTH = $clog2(N_REQ);

  // requester side, flattened: requester r owns i_data[r*WIDTH_PKT +: WIDTH_PKT]
  logic [N_REQ*WIDTH_PKT-1:0] i_data;
  logic [N_REQ-1:0]           i_valid;
  logic [N_REQ-1:0]           i_last;
  logic [N_REQ-1:0]           o_ready;

  // fabric-port side
  logic [WIDTH_PKT-1:0]       o_data;
  logic                       o_valid;
  logic [SRC_WIDTH-1:0]       o_src;
  logic                       i_ready;

  // environment: requesters plus the fabric node's ready
  modport master (
    output i_data, i_valid, i_last, i_ready,
    input  o_ready, o_data, o_valid, o_src
  );

  // arbiter
  modport slave (
    input  i_data, i_valid, i_last, i_ready,
    output o_ready, o_data, o_valid, o_src
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter with burst locking. It shares one fabric-port input between N_REQ requesters.
// Latency: 1 cycle from accept to o_valid. Throughput is 1 packet/cycle, and a drain and a load can happen in the same cycle.
// Backpressure: the output register holds while o_valid && !i_ready. No requester is granted until it drains.
module noc_port_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH_PKT = 512,
  parameter int MAX_BURST = 8
) (
  input logic               clk,
  input logic               rst,
  noc_port_arbiter_if.slave bus
);
  localparam int SRC_WIDTH = $clog2(N_REQ);
  localparam int BEAT_W    = $clog2(MAX_BURST) + 1;
  localparam bit LOCK_EN   = (MAX_BURST > 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [SRC_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_WIDTH-1:0] owner_q, owner_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic                 o_valid_q;
  logic [WIDTH_PKT-1:0] o_data_q;
  logic [SRC_WIDTH-1:0] o_src_q;

  logic                 space;
  logic [SRC_WIDTH-1:0] sel;
  logic                 sel_found;
  logic [N_REQ-1:0]     ready_vec;
  logic [SRC_WIDTH-1:0] grant_idx;
  logic                 accept;
  logic                 acc_last;
  logic [WIDTH_PKT-1:0] acc_data;

  // (base + off) mod N_REQ, where base < N_REQ and off <= N_REQ. Correct for non-power-of-2 N_REQ.
  function automatic logic [SRC_WIDTH-1:0] wrap_add(input logic [SRC_WIDTH-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return SRC_WIDTH'(s);
  endfunction

  assign space = !o_valid_q || bus.i_ready;

  // Round-robin search from rr_ptr. The locked owner overrides the search. Nothing is granted during reset.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    ready_vec = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!sel_found && bus.i_valid[wrap_add(rr_ptr_q, k)]) begin
        sel       = wrap_add(rr_ptr_q, k);
        sel_found = 1'b1;
      end
    end
    if (rst) begin
      if (state_q == LOCKED) ready_vec[owner_q] = space;
      else if (sel_found)    ready_vec[sel]     = space;
    end
  end

  assign grant_idx   = (state_q == LOCKED) ? owner_q : sel;
  assign accept      = |(ready_vec & bus.i_valid);
  assign acc_last    = bus.i_last[grant_idx];
  assign bus.o_ready = ready_vec;

  // Select the granted requester's packet for loading into the output register.
  always_comb begin
    acc_data = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant_idx == SRC_WIDTH'(r)) acc_data = bus.i_data[r*WIDTH_PKT +: WIDTH_PKT];
    end
  end

  // Lock and pointer transitions. They advance only on an accepted packet.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (acc_last || !LOCK_EN) begin
            rr_ptr_d = wrap_add(sel, 1);
          end else begin
            state_d    = LOCKED;
            owner_d    = sel;
            beat_cnt_d = BEAT_W'(1);
          end
        end
        LOCKED: begin
          // reaching MAX_BURST forces a release; the owner's remaining packets re-arbitrate
          if (acc_last || beat_cnt_q == BEAT_W'(MAX_BURST - 1)) begin
            state_d    = IDLE;
            rr_ptr_d   = wrap_add(owner_q, 1);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Arbitration state register. Reset aborts any lock in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Output stage: load on accept, empty on drain, hold while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_src_q   <= '0;
    end else if (accept) begin
      o_valid_q <= 1'b1;
      o_data_q  <= acc_data;
      o_src_q   <= grant_idx;
    end else if (space) begin
      o_valid_q <= 1'b0;
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_src   = o_src_q;
endmodule

// File: tb/tb_noc_port_arbiter.sv
// Bench for noc_port_arbiter. Requester queues feed the DUT, and expected packets are queued at stimulus time.
// A negedge monitor pops the expected packets and compares them on each fabric transfer. It also checks hold-under-stall and one-hot grant.
// Backpressure: i_ready is either held at 1 or stalled randomly, 1 cycle in STALL_FACTOR on average.
module tb_noc_port_arbiter;
  localparam int N_REQ        = 4;
  localparam int WIDTH_PKT    = 512;
  localparam int MAX_BURST    = 8;
  localparam int STALL_FACTOR = 5;

  typedef struct packed {
    logic                 last;
    logic [WIDTH_PKT-1:0] data;
  } pkt_t;

  typedef struct packed {
    logic [1:0]           src;
    logic [WIDTH_PKT-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  noc_port_arbiter_if #(.N_REQ(N_REQ), .WIDTH_PKT(WIDTH_PKT)) bus ();

  noc_port_arbiter #(.N_REQ(N_REQ), .WIDTH_PKT(WIDTH_PKT), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pkt_t rq[N_REQ][$];
  exp_t exp_q[$];
  exp_t exp_src[N_REQ][$];
  int   xfer_cyc[$];
  int   acc_cnt[N_REQ];
  bit   per_src_mode = 1'b0;
  bit   stall_en     = 1'b0;
  int   xfer_total   = 0;
  int   cyc          = 0;
  int   checks       = 0;
  int   errors       = 0;

  always @(posedge clk) cyc++;

  function automatic logic [WIDTH_PKT-1:0] mk_data(input int src, input int seq);
    logic [31:0] tag;
    tag = 32'h00A5_0000 | (32'(src) << 24) | 32'(seq & 16'hFFFF);
    return {16{tag}};
  endfunction

  task automatic add_pkt(input int src, input int seq, input bit last);
    pkt_t p;
    p.last = last;
    p.data = mk_data(src, seq);
    rq[src].push_back(p);
  endtask

  task automatic add_exp(input int src, input int seq);
    exp_t e;
    e.src  = 2'(src);
    e.data = mk_data(src, seq);
    if (per_src_mode) exp_src[src].push_back(e);
    else              exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at t=%0t", name, got, want, $time);
    end
  endtask

  function automatic int pending();
    int n;
    n = exp_q.size();
    for (int r = 0; r < N_REQ; r++) n += exp_src[r].size();
    return n;
  endfunction

  task automatic clear_all();
    for (int r = 0; r < N_REQ; r++) begin
      rq[r].delete();
      exp_src[r].delete();
      acc_cnt[r] = 0;
    end
    exp_q.delete();
    xfer_cyc.delete();
  endtask

  task automatic rst_assert();
    @(posedge clk);
    #3;
    rst = 1'b0;
    clear_all();
  endtask

  task automatic rst_release();
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  task automatic do_reset();
    rst_assert();
    repeat (2) @(posedge clk);
    rst_release();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain_left"}, 64'(pending()), 64'd0);
    @(posedge clk);
  endtask

  // Requester model: sample grants at negedge, retire the granted heads after the edge, then present the new heads.
  initial begin : req_driver
    logic [N_REQ-1:0] acc;
    bus.i_valid = '0;
    bus.i_last  = '0;
    bus.i_data  = '0;
    forever begin
      @(negedge clk);
      acc = bus.o_ready & bus.i_valid;
      @(posedge clk);
      #1;
      for (int r = 0; r < N_REQ; r++) begin
        if (acc[r] && rq[r].size() > 0) begin
          void'(rq[r].pop_front());
          acc_cnt[r]++;
        end
      end
      for (int r = 0; r < N_REQ; r++) begin
        if (rq[r].size() > 0) begin
          bus.i_valid[r] = 1'b1;
          bus.i_last[r]  = rq[r][0].last;
          bus.i_data[r*WIDTH_PKT +: WIDTH_PKT] = rq[r][0].data;
        end else begin
          bus.i_valid[r] = 1'b0;
          bus.i_last[r]  = 1'b0;
        end
      end
    end
  end

  // Fabric ready: always ready, or random stalls while stall_en is set.
  initial begin : fabric_ready
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.i_ready = stall_en ? ($urandom_range(0, STALL_FACTOR - 1) != 0) : 1'b1;
    end
  end

  // Monitor: compares each fabric transfer against the scoreboard, checks that the register holds under stall, and checks one-hot grant.
  logic                 prev_stall = 1'b0;
  logic [WIDTH_PKT-1:0] prev_data;
  logic [1:0]           prev_src;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (!$onehot0(bus.o_ready)) begin
        errors++;
        $display("FAIL ready_onehot got %b want one-hot or zero at t=%0t", bus.o_ready, $time);
      end
      if (prev_stall) begin
        checks++;
        if (!(bus.o_valid && bus.o_data == prev_data && bus.o_src == prev_src)) begin
          errors++;
          $display("FAIL stall_hold got v=%b src=%0d d=%h want v=1 src=%0d d=%h", bus.o_valid, bus.o_src,
                   bus.o_data[31:0], prev_src, prev_data[31:0]);
        end
      end
      if (bus.o_valid && bus.i_ready) begin
        xfer_total++;
        xfer_cyc.push_back(cyc);
        checks++;
        if (per_src_mode ? (exp_src[bus.o_src].size() == 0) : (exp_q.size() == 0)) begin
          errors++;
          $display("FAIL unexpected_xfer got src=%0d d=%h want nothing at t=%0t", bus.o_src, bus.o_data[31:0], $time);
        end else begin
          e = per_src_mode ? exp_src[bus.o_src].pop_front() : exp_q.pop_front();
          if (bus.o_src !== e.src || bus.o_data !== e.data) begin
            errors++;
            $display("FAIL xfer got src=%0d d=%h want src=%0d d=%h at t=%0t", bus.o_src, bus.o_data[31:0],
                     e.src, e.data[31:0], $time);
          end
        end
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_data  = bus.o_data;
      prev_src   = bus.o_src;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout want $finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    for (int r = 0; r < N_REQ; r++) acc_cnt[r] = 0;

    // 1: reset holds grants off even with all requesters valid; first grant goes to requester 0
    rst_assert();
    for (int r = 0; r < N_REQ; r++) add_pkt(r, r, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("rst_o_ready", 64'(bus.o_ready), 64'd0);
    check("rst_o_valid", 64'(bus.o_valid), 64'd0);
    check("rst_o_data",  bus.o_data[63:0], 64'd0);
    check("rst_o_src",   64'(bus.o_src),   64'd0);
    for (int r = 0; r < N_REQ; r++) add_exp(r, r);
    rst_release();
    @(negedge clk);
    @(negedge clk);
    check("first_valid", 64'(bus.o_valid), 64'd1);
    check("first_src",   64'(bus.o_src),   64'd0);
    wait_drain("t1", 50);

    // 2: single-packet round robin, 0,1,2,3,0,1,2,3 with no bubbles
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N_REQ; r++) begin
        add_pkt(r, 10 + k*4 + r, 1'b1);
        add_exp(r, 10 + k*4 + r);
      end
    wait_drain("t2", 50);
    check("rr_xfers", 64'(xfer_cyc.size()), 64'd8);
    if (xfer_cyc.size() == 8) check("rr_no_bubble", 64'(xfer_cyc[7] - xfer_cyc[0]), 64'd7);

    // 3: requester 1 moves rr_ptr to 2; then requester 2 locks for 3 packets, followed by 3,0,1
    do_reset();
    add_pkt(1, 20, 1'b1); add_exp(1, 20);
    wait_drain("t3a", 50);
    add_pkt(2, 21, 1'b0); add_pkt(2, 22, 1'b0); add_pkt(2, 23, 1'b1);
    add_pkt(0, 24, 1'b1); add_pkt(1, 25, 1'b1); add_pkt(3, 26, 1'b1);
    add_exp(2, 21); add_exp(2, 22); add_exp(2, 23);
    add_exp(3, 26); add_exp(0, 24); add_exp(1, 25);
    wait_drain("t3b", 50);

    // 4: MAX_BURST forced release: 8 packets from requester 1, then requester 3, then requester 1 resumes
    do_reset();
    for (int i = 0; i < 10; i++) add_pkt(1, 30 + i, 1'b0);
    add_pkt(3, 99, 1'b1);
    for (int i = 0; i < 8; i++) add_exp(1, 30 + i);
    add_exp(3, 99);
    add_exp(1, 38); add_exp(1, 39);
    wait_drain("t4", 60);

    // 5: random backpressure, 1000 packets, checked per source
    do_reset();
    per_src_mode = 1'b1;
    for (int s = 0; s < 250; s++)
      for (int r = 0; r < N_REQ; r++) begin
        add_pkt(r, 1000 + s, (s % 11 == 10) || (s % 7 == 0) || (s == 249));
        add_exp(r, 1000 + s);
      end
    xfer_total = 0;
    stall_en   = 1'b1;
    wait_drain("t5", 8000);
    check("bp_total", 64'(xfer_total), 64'd1000);
    stall_en     = 1'b0;
    per_src_mode = 1'b0;

    // 6: reset while requester 0 is mid-burst
    do_reset();
    for (int i = 0; i < 5; i++) add_pkt(0, 60 + i, i == 4);
    add_exp(0, 60); add_exp(0, 61);
    n = 0;
    while (acc_cnt[0] < 2 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("mid_accepts", 64'(acc_cnt[0]), 64'd2);
    check("mid_pending", 64'(exp_q.size()), 64'd1);
    check("mid_held_vld", 64'(bus.o_valid), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_o_valid", 64'(bus.o_valid), 64'd0);
    check("async_o_data",  bus.o_data[63:0], 64'd0);
    clear_all();
    add_pkt(1, 70, 1'b1); add_exp(1, 70);
    repeat (2) @(posedge clk);
    rst_release();
    wait_drain("t6a", 50);
    do_reset();
    add_pkt(0, 71, 1'b1); add_pkt(1, 72, 1'b1);
    add_exp(0, 71); add_exp(1, 72);
    wait_drain("t6b", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Shares one fabric-port input node (the packet/valid/ready triple into fabric_interface_sw) between N_REQ packetizer requesters.
- Arbitration is round-robin with optional burst locking: a requester can hold the port for a multi-packet transaction until it marks the last packet, up to MAX_BURST packets.
- Output is one registered stage that can accept a new packet every cycle. It drives i_packets_in[k] / i_valids_in[k] directly and takes i_readys_out[k] as its ready.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH_PKT, 512, packet width; matches WIDTH_RTL of the fabric port.
- MAX_BURST, 8, maximum consecutive packets granted to one locked owner (1 disables locking).
- SRC_WIDTH, $clog2(N_REQ), width of source-index output (localparam).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- i_data  in  N_REQ*WIDTH_PKT  requester packets, flattened; requester r occupies [r*WIDTH_PKT +: WIDTH_PKT].
- i_valid  in  N_REQ  per-requester packet valid.
- i_last  in  N_REQ  per-requester last-packet-of-burst flag, qualified by i_valid.
- o_ready  out  N_REQ  per-requester accept; at most one bit high (one-hot or zero).
- o_data  out  WIDTH_PKT  registered packet to the fabric port.
- o_valid  out  1  registered valid to the fabric port.
- o_src  out  SRC_WIDTH  index of the requester that supplied o_data.
- i_ready  in  1  fabric-port ready (i_readys_out of the node).

Behaviour:
- Reset (rst=0, async): o_valid=0, o_data=0, o_src=0, o_ready=0, state=IDLE, rr_ptr=0, owner=0, beat_cnt=0. o_ready is forced 0 while rst=0.
- Output stage:
  - space = !o_valid || i_ready.
  - Accept on requester r when o_ready[r] && i_valid[r].
  - On accept: o_data<=i_data[r], o_src<=r, o_valid<=1 at the next clk edge.
  - If space && no accept: o_valid<=0.
  - If !space: the register holds.
  - Latency is 1 cycle, accept to o_valid. Back-to-back throughput is 1 packet/cycle when i_ready=1; a simultaneous drain and load in the same cycle leaves no bubble.
- Grant (combinational from registered state and i_valid):
  - IDLE: sel = first r with i_valid[r]=1, searching rr_ptr, rr_ptr+1, … mod N_REQ. o_ready[sel]=space; all other bits 0.
  - LOCKED: o_ready[owner]=space; all other bits 0.
  - o_ready does not depend on i_last.
- State transitions, evaluated only on an accept; no accept means no change:
  - IDLE, accept with i_last=1 or MAX_BURST=1: stay IDLE, rr_ptr<=sel+1 mod N_REQ.
  - IDLE, accept with i_last=0 and MAX_BURST>1: go LOCKED, owner<=sel, beat_cnt<=1.
  - LOCKED, accept with i_last=1 or beat_cnt==MAX_BURST-1: go IDLE, rr_ptr<=owner+1 mod N_REQ, beat_cnt<=0. Hitting the MAX_BURST limit is a forced release; the owner's remaining packets re-arbitrate normally.
  - LOCKED, accept otherwise: beat_cnt<=beat_cnt+1.
- Boundary conditions:
  - Owner deasserts i_valid while LOCKED: the lock is held and other requesters wait. There is no timeout, and the owner is responsible for completing its burst.
  - All i_valid=0 in IDLE: o_ready=0 and rr_ptr is unchanged.
  - i_ready=0 with o_valid=1: no grant; the register and o_src stay stable until drained.
  - i_valid or i_data changing while not granted has no effect.
  - Reset asserted mid-burst aborts the lock and drops any held o_data.
  - Wrap-around: rr_ptr and owner+1 wrap modulo N_REQ, including non-power-of-2 N_REQ.
- beat_cnt width: $clog2(MAX_BURST)+1; it never exceeds MAX_BURST-1.

Test Plan:
1. Reset: hold rst=0 with all i_valid=1 → o_ready=0000, o_valid=0, o_data=0. Release rst; first grant goes to requester 0, with o_valid=1 on the following cycle and o_src=0.
2. Round-robin: i_valid=1111, i_last=1111, i_ready=1, unique data per requester for 8 cycles → o_src sequence 0,1,2,3,0,1,2,3 with no bubble cycles and data matching each source.
3. Burst lock: requester 2 sends 3 packets with i_last=0,0,1 while requesters 0, 1 and 3 are valid → o_src=2,2,2 consecutively, then 3,0,1.
4. Forced release, MAX_BURST=8: requester 1 sends 10 packets all with i_last=0 while requester 3 is valid → 8×o_src=1, then o_src=3, then requester 1 resumes.
5. Backpressure: drive i_ready with the random stall pattern used by the fabric-port benches (STALL_FACTOR=5) for 1000 packets from 4 sources → every packet is delivered exactly once, in per-source order. o_data and o_src are held stable whenever o_valid=1 && i_ready=0, and o_ready stays one-hot or zero throughout.
6. Reset mid-burst: requester 0 is locked after 2 of 5 packets; pulse rst=0 → o_valid=0 immediately (async). After release, requester 1 (valid) competes from rr_ptr=0, and requester 0 wins only if it is valid.
